// File: rtl/servo_pwm_generator_if.sv
// Position request channel for the servo PWM generator (valid/ready).
interface servo_pwm_generator_if;
    logic [7:0] pos_data;
    logic       pos_valid;
    logic       pos_ready;

    modport master (output pos_data, output pos_valid, input pos_ready);
    modport slave  (input pos_data, input pos_valid, output pos_ready);
endinterface

// File: rtl/servo_pwm_generator.sv
// Servo PWM frame generator. The divided clock is sampled as data and
// edge-detected into a one-cycle tick; all frame timing counts ticks.
// A one-entry shadow register takes new positions, which are applied only
// at frame start so the running frame is never disturbed.
module servo_pwm_generator #(
    parameter int PERIOD_TICKS    = 2558,
    parameter int MIN_PULSE_TICKS = 128,
    parameter int MAX_PULSE_TICKS = 256,
    parameter int CNT_W           = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clockdivided,
    servo_pwm_generator_if.slave   pos,
    output logic                   pwm_out,
    output logic                   frame_start,
    output logic                   active
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W:0]   MIN_EXT  = (CNT_W+1)'(MIN_PULSE_TICKS);
    localparam logic [CNT_W:0]   MAX_EXT  = (CNT_W+1)'(MAX_PULSE_TICKS);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD_TICKS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
    logic [7:0]       shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic             clk_d_q, clk_d_d;
    logic             pwm_q, pwm_d;
    logic             frame_start_q, frame_start_d;
    logic             active_q, active_d;

    logic             tick;
    logic             accept;
    logic             consume;
    logic [CNT_W:0]   pulse_sum;
    logic [CNT_W:0]   pulse_clamped;

    assign tick          = clockdivided & ~clk_d_q;
    assign accept        = pos.pos_valid & ~shadow_full_q;
    assign pos.pos_ready = ~shadow_full_q;
    assign pwm_out       = pwm_q;
    assign frame_start   = frame_start_q;
    assign active        = active_q;

    // Map shadowed position to a pulse width, widened so the sum cannot wrap.
    always_comb begin
        pulse_sum     = MIN_EXT + (CNT_W+1)'(shadow_q);
        pulse_clamped = (pulse_sum > MAX_EXT) ? MAX_EXT : pulse_sum;
    end

    // Shadow register: fill on accept, drain when a frame start consumes it.
    // Accept needs an empty shadow and consume a full one, so they never collide.
    always_comb begin
        clk_d_d       = clockdivided;
        shadow_d      = accept ? pos.pos_data : shadow_q;
        shadow_full_d = accept | (shadow_full_q & ~consume);
    end

    // Frame FSM. period_cnt holds the number of ticks elapsed in the frame,
    // counting the start tick as 1, so the pulse ends after pulse_len ticks
    // and the frame restarts after PERIOD_TICKS ticks.
    always_comb begin
        state_d       = state_q;
        period_cnt_d  = period_cnt_q;
        pulse_len_d   = pulse_len_q;
        pwm_d         = pwm_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        consume       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                period_cnt_d = '0;
                pwm_d        = 1'b0;
                if (tick && shadow_full_q) begin
                    pulse_len_d   = pulse_clamped[CNT_W-1:0];
                    consume       = 1'b1;
                    active_d      = 1'b1;
                    frame_start_d = 1'b1;
                    pwm_d         = 1'b1;
                    period_cnt_d  = ONE_C;
                    state_d       = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    period_cnt_d = period_cnt_q + ONE_C;
                    if (period_cnt_q == pulse_len_q) begin
                        pwm_d   = 1'b0;
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (tick) begin
                    if (period_cnt_q == PERIOD_C) begin
                        if (shadow_full_q) begin
                            pulse_len_d = pulse_clamped[CNT_W-1:0];
                            consume     = 1'b1;
                            active_d    = 1'b1;
                        end
                        frame_start_d = 1'b1;
                        pwm_d         = 1'b1;
                        period_cnt_d  = ONE_C;
                        state_d       = ST_HIGH;
                    end else begin
                        period_cnt_d = period_cnt_q + ONE_C;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                pwm_d        = 1'b0;
                period_cnt_d = '0;
            end
        endcase
    end

    // State registers; clk_d resets high so a divided clock already high at
    // reset release does not produce a spurious tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            period_cnt_q  <= '0;
            pulse_len_q   <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            clk_d_q       <= 1'b1;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            pulse_len_q   <= pulse_len_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            clk_d_q       <= clk_d_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
        end
    end

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Directed bench for servo_pwm_generator. The divided clock is a square wave
// with a tick every second system clock; the bench counts its own rising
// edges and measures pulse and frame lengths in ticks.
module tb_servo_pwm_generator;

    logic clock;
    logic reset;
    logic clockdivided;
    logic pwm_out;
    logic frame_start;
    logic active;

    servo_pwm_generator_if pos_if ();

    servo_pwm_generator dut (
        .clock        (clock),
        .reset        (reset),
        .clockdivided (clockdivided),
        .pos          (pos_if),
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .active       (active)
    );

    int  errors = 0;
    int  checks = 0;
    int  tick_no = 0;
    bit  div_en = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divided clock generator: toggles on the falling edge when enabled.
    initial begin
        clockdivided = 1'b0;
        forever begin
            @(negedge clock);
            if (div_en) begin
                clockdivided = ~clockdivided;
                if (clockdivided) tick_no++;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(output int t);
        bit found;
        found = 0;
        t = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            @(posedge clock); #1;
            if (frame_start === 1'b1) begin
                found = 1;
                t = tick_no;
            end
        end
        check("frame_start_wait", int'(found), 1);
    endtask

    task automatic wait_low(output int t);
        bit found;
        found = 0;
        t = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            @(posedge clock); #1;
            if (pwm_out === 1'b0) begin
                found = 1;
                t = tick_no;
            end
        end
        check("pwm_fall_wait", int'(found), 1);
    endtask

    task automatic send_pos(input logic [7:0] v);
        bit found;
        found = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            if (pos_if.pos_ready === 1'b1) found = 1;
            else begin @(posedge clock); #1; end
        end
        check("ready_wait", int'(found), 1);
        pos_if.pos_data  = v;
        pos_if.pos_valid = 1'b1;
        @(posedge clock); #1;
        pos_if.pos_valid = 1'b0;
        pos_if.pos_data  = 8'hxx;
    endtask

    task automatic measure(input logic [7:0] v, input int exp_high, input string tag);
        int f;
        int t;
        send_pos(v);
        wait_fs(f);
        wait_low(t);
        check(tag, t - f, exp_high);
    endtask

    initial begin
        int f;
        int f2;
        int t;
        int bad;

        reset            = 1'b1;
        pos_if.pos_data  = 8'h00;
        pos_if.pos_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_fs", int'(frame_start), 0);
        check("rst_active", int'(active), 0);
        check("rst_ready", int'(pos_if.pos_ready), 1);

        // 1: idle for 5000 ticks without a position
        @(negedge clock);
        reset  = 1'b0;
        div_en = 1'b1;
        bad = 0;
        repeat (10000) begin
            @(posedge clock); #1;
            if (pwm_out !== 1'b0 || frame_start !== 1'b0 || active !== 1'b0 ||
                pos_if.pos_ready !== 1'b1) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_ticks", tick_no >= 5000, 1);

        // 2: position 0 -> 128 high, 2430 low, 2558 frame
        pos_if.pos_data  = 8'd0;
        pos_if.pos_valid = 1'b1;
        check("p0_ready_before", int'(pos_if.pos_ready), 1);
        @(posedge clock); #1;
        pos_if.pos_valid = 1'b0;
        check("p0_ready_after", int'(pos_if.pos_ready), 0);
        wait_fs(f);
        check("p0_active", int'(active), 1);
        check("p0_pwm_high", int'(pwm_out), 1);
        check("p0_ready_consumed", int'(pos_if.pos_ready), 1);
        wait_low(t);
        check("p0_high", t - f, 128);
        wait_fs(f2);
        check("p0_low", f2 - t, 2430);
        check("p0_period", f2 - f, 2558);

        // 3: clamping and linear mapping
        measure(8'd200, 256, "p200_high");
        measure(8'd128, 256, "p128_high");
        measure(8'd64, 192, "p64_high");

        // 4: update mid-HIGH does not touch the running pulse
        send_pos(8'd0);
        wait_fs(f);
        repeat (50) @(posedge clock);
        #1;
        send_pos(8'd100);
        check("mid_ready_low", int'(pos_if.pos_ready), 0);
        wait_low(t);
        check("mid_cur_high", t - f, 128);
        check("mid_ready_still_low", int'(pos_if.pos_ready), 0);
        wait_fs(f);
        check("mid_ready_at_fs", int'(pos_if.pos_ready), 1);
        wait_low(t);
        check("mid_next_high", t - f, 228);

        // 5: back-to-back 10 then 20
        pos_if.pos_data  = 8'd10;
        pos_if.pos_valid = 1'b1;
        check("b2b_ready_first", int'(pos_if.pos_ready), 1);
        @(posedge clock); #1;
        pos_if.pos_data = 8'd20;
        check("b2b_ready_stall", int'(pos_if.pos_ready), 0);
        wait_fs(f);
        check("b2b_ready_at_fs", int'(pos_if.pos_ready), 1);
        @(posedge clock); #1;
        pos_if.pos_valid = 1'b0;
        check("b2b_second_taken", int'(pos_if.pos_ready), 0);
        wait_low(t);
        check("b2b_high_10", t - f, 138);
        wait_fs(f);
        wait_low(t);
        check("b2b_high_20", t - f, 148);

        // 6: asynchronous reset in the middle of a HIGH phase
        wait_fs(f);
        repeat (100) @(posedge clock);
        #1;
        check("rst_mid_pwm_before", int'(pwm_out), 1);
        #2;
        reset        = 1'b1;
        div_en       = 1'b0;
        clockdivided = 1'b1;
        #1;
        check("rst_mid_pwm", int'(pwm_out), 0);
        check("rst_mid_active", int'(active), 0);
        check("rst_mid_ready", int'(pos_if.pos_ready), 1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        send_pos(8'd30);
        bad = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (frame_start !== 1'b0 || pwm_out !== 1'b0) bad++;
        end
        check("rst_no_false_tick", bad, 0);
        check("rst_held_active", int'(active), 0);
        div_en = 1'b1;
        wait_fs(f);
        check("rst_resume_active", int'(active), 1);
        wait_low(t);
        check("rst_resume_high", t - f, 158);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
